// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Handshake: load is a single-cycle capture strobe with no ready; every clock
// edge with load=1 copies value/dp_en/blank_lz into the shadow registers, and
// the pins reflect the new data from the following edge onward.
module sevenseg_mux_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD         = 2,
  parameter int ACTIVE_LOW_AN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW_AN != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

  // Active-low segment pattern for bits [6:0]; the DP bit is handled separately.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h08;
      4'h1: s = 7'h6D;
      4'h2: s = 7'h22;
      4'h3: s = 7'h24;
      4'h4: s = 7'h45;
      4'h5: s = 7'h14;
      4'h6: s = 7'h10;
      4'h7: s = 7'h2D;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h01;
      4'hB: s = 7'h50;
      4'hC: s = 7'h1A;
      4'hD: s = 7'h60;
      4'hE: s = 7'h12;
      default: s = 7'h13;
    endcase
    return s;
  endfunction

  logic [4*NUM_DIGITS-1:0] sv_q, sv_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic                    slz_q, slz_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS-1:0]   an_on;
  logic [3:0]              nib;
  logic                    dp_on;
  logic                    blank_cur;
  logic                    zero_above;

  // Shadow capture: inputs only matter on edges where load is high.
  always_comb begin
    sv_d  = sv_q;
    sdp_d = sdp_q;
    slz_d = slz_q;
    if (load) begin
      sv_d  = value;
      sdp_d = dp_en;
      slz_d = blank_lz;
    end
  end

  // Scan position: cnt walks one slot, idx advances on each slot wrap.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_d = '0;
      else                                 idx_d = idx_q + IDX_W'(1);
    end
  end

  // Pin values for the next edge, built from the current scan state and shadows.
  always_comb begin
    blank_vec  = '0;
    an_on      = '0;
    nib        = 4'h0;
    dp_on      = 1'b0;
    blank_cur  = 1'b0;
    zero_above = 1'b1;
    an_d       = AN_OFF;
    seg_d      = 8'hFF;
    // A digit is a leading zero when it and every more-significant nibble is 0.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above & (sv_q[4*i +: 4] == 4'h0);
      blank_vec[i] = slz_q & zero_above & (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = sv_q[4*i +: 4];
        dp_on     = sdp_q[i];
        blank_cur = blank_vec[i];
        an_on[i]  = 1'b1;
      end
    end
    // The guard keeps every anode dark at the start of each slot to avoid ghosting.
    if (cnt_q >= CNT_W'(GUARD)) begin
      an_d  = (ACTIVE_LOW_AN != 0) ? ~an_on : an_on;
      seg_d = {~dp_on, blank_cur ? 7'h7F : hex_to_seg(nib)};
    end
  end

  // State and registered pins; reset drops the display dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q  <= '0;
      sdp_q <= '0;
      slz_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= AN_OFF;
      seg_q <= 8'hFF;
    end else begin
      sv_q  <= sv_d;
      sdp_q <= sdp_d;
      slz_q <= slz_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Bench for sevenseg_mux_driver with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
// Expected lit codes per digit are written out by hand for each scenario; the
// bench lays them onto the 32-cycle frame (2 dark + 6 lit cycles per slot).
module tb_sevenseg_mux_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  seg;

  sevenseg_mux_driver #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(8),
    .GUARD(2),
    .ACTIVE_LOW_AN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .dp_en(dp_en),
    .blank_lz(blank_lz),
    .load(load),
    .an(an),
    .seg(seg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  int          edge_n = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  cur_codes[4];

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got an=%b seg=%h, expected an=%b seg=%h",
               name, $time, got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  // Scoreboard monitor: every registered pin update is compared at the falling edge.
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan", {an, seg}, e);
    end
  end

  task automatic set_codes(input logic [7:0] c3, input logic [7:0] c2,
                           input logic [7:0] c1, input logic [7:0] c0);
    cur_codes[3] = c3;
    cur_codes[2] = c2;
    cur_codes[1] = c1;
    cur_codes[0] = c0;
  endtask

  // Driver: advance one edge and queue what the pins must show after it.
  task automatic tick();
    int          pos;
    int          slot;
    int          c;
    logic [11:0] e;
    @(posedge clk);
    edge_n++;
    pos  = (edge_n - 1) % 32;
    slot = pos / 8;
    c    = pos % 8;
    if (c < 2) e = {4'hF, 8'hFF};
    else       e = {~(4'b0001 << slot), cur_codes[slot]};
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Step until the next edge lands on the given frame position.
  task automatic advance_to(input int target);
    while ((edge_n % 32) != target) tick();
  endtask

  // Pulse load for one edge; the new codes apply from the edge after it.
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz,
                         input logic [7:0] c3, input logic [7:0] c2,
                         input logic [7:0] c1, input logic [7:0] c0);
    value    = v;
    dp_en    = dp;
    blank_lz = lz;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    set_codes(c3, c2, c1, c0);
  endtask

  initial begin
    rst      = 1'b0;
    value    = 16'h0;
    dp_en    = 4'h0;
    blank_lz = 1'b0;
    load     = 1'b0;
    set_codes(8'h88, 8'h88, 8'h88, 8'h88);

    // Reset release: all shadows zero, no blanking, so every digit shows 0.
    #2 rst = 1'b1;
    #1 check("reset_state", {an, seg}, {4'hF, 8'hFF});
    @(negedge clk);
    #1 rst = 1'b0;
    edge_n = 0;
    run(40);

    // Decode 12AF: digit0=F, digit1=A, digit2=2, digit3=1.
    do_load(16'h12AF, 4'h0, 1'b0, 8'hED, 8'hA2, 8'h81, 8'h93);
    run(33);

    // Decimal point on digit0 and digit3 on top of a decode.
    do_load(16'h12AF, 4'b1001, 1'b0, 8'h6D, 8'hA2, 8'h81, 8'h13);
    run(32);

    // Leading-zero blanking of 0050.
    do_load(16'h0050, 4'h0, 1'b1, 8'hFF, 8'hFF, 8'h94, 8'h88);
    run(32);

    // All zero with blanking: only digit0 visible.
    do_load(16'h0000, 4'h0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h88);
    run(32);

    // DP on a blanked digit still shows the point alone.
    do_load(16'h0000, 4'b0100, 1'b1, 8'hFF, 8'h7F, 8'hFF, 8'h88);
    run(32);

    // Input changes without load must not reach the pins.
    value    = 16'h1234;
    dp_en    = 4'h0;
    blank_lz = 1'b0;
    run(20);

    // Load while digit1 is lit: its code flips on the following edge.
    advance_to(8 + 3);
    do_load(16'h1234, 4'h0, 1'b0, 8'hED, 8'hA2, 8'hA4, 8'hC5);
    run(36);

    // Async reset while digit2 is lit; shadows must come back cleared.
    do_load(16'h9E7D, 4'b0010, 1'b1, 8'h84, 8'h92, 8'h2D, 8'hE0);
    advance_to(16 + 4);
    tick();
    value    = 16'hFFFF;
    dp_en    = 4'hF;
    blank_lz = 1'b1;
    @(negedge clk);
    #1 check("pre_reset_lit", {an, seg}, {4'b1011, 8'h92});
    rst = 1'b1;
    #1 check("async_reset", {an, seg}, {4'hF, 8'hFF});
    @(negedge clk);
    #1 check("reset_hold", {an, seg}, {4'hF, 8'hFF});
    rst    = 1'b0;
    edge_n = 0;
    set_codes(8'h88, 8'h88, 8'h88, 8'h88);
    run(34);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_mux_driver.md
# sevenseg_mux_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It captures a packed hex value, decodes each nibble to active-low segments, and scans the digit anodes at a programmable refresh rate. Extras:
- leading-zero blanking;
- per-digit decimal point;
- an anode-off guard interval between digits to suppress ghosting.

It sits between datapath result registers (e.g. multiplier output) and the board display pins, and replaces the single-digit combinational hex decoder.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal 1..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; legal ≥ GUARD+1.
- GUARD, 2: cycles at the start of each slot with all anodes off; legal 0..REFRESH_DIV-1.
- ACTIVE_LOW_AN, 1: 1 means anodes active-low (inactive = 1); 0 means active-high (inactive = 0).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp_en  in  NUM_DIGITS  decimal-point enable per digit.
- blank_lz  in  1  leading-zero blanking enable; sampled with load.
- load  in  1  capture strobe for value, dp_en and blank_lz.
- an  out  NUM_DIGITS  digit anode enables, one-hot when active.
- seg  out  8  segments, active-low; seg[7] = DP, seg[6:0] per board pinout.

## Operation
- Shadow registers sv, sdp, slz capture value, dp_en and blank_lz on any clock edge with load=1. Without load, input changes have no effect. All shadows reset to 0.
- Scan counter cnt counts 0..REFRESH_DIV-1. On wrap, digit index idx advances 0→1→…→NUM_DIGITS-1→0.
- Nibble decode, written as full 8-bit codes with DP off (bit7=1):
  - 0=88, 1=ED, 2=A2, 3=A4, 4=C5, 5=94, 6=90, 7=AD
  - 8=80, 9=84, A=81, b=D0, C=9A, d=E0, E=92, F=93
- DP: if sdp[idx]=1, seg[7] is forced to 0.
- Leading-zero blanking, applied when slz=1: digit i is blanked if every nibble of sv at positions ≥ i is zero and i ≠ 0. Digit 0 is never blanked.
  - A blanked digit drives seg[6:0]=7'h7F; DP still follows sdp.
- Guard interval: while cnt < GUARD, an = all inactive and seg = 8'hFF.
- Otherwise an = one-hot(idx), polarity per ACTIVE_LOW_AN.
- At most one anode is active in any cycle.

## Timing
- Reset, asynchronous: an = all inactive (4'b1111 at default), seg = 8'hFF, cnt = 0, idx = 0, shadows = 0.
  - Asserting rst mid-scan forces these values immediately, without waiting for a clock edge.
- an and seg are registered. Each edge loads them from the pre-edge cnt, idx and shadow values, so outputs lag scan state by one cycle.
- After rst deasserts, edges 1..GUARD drive the guard. Digit 0 first lights on edge GUARD+1 and stays lit for REFRESH_DIV-GUARD cycles.
- Slot period is REFRESH_DIV cycles; frame period is NUM_DIGITS*REFRESH_DIV cycles.
- load on edge t updates the shadows at edge t; seg and an reflect the new data from edge t+1, i.e. 2-cycle input-to-pin latency.
  - If load lands mid-slot, the currently lit digit changes on that next edge.
- load held high captures every cycle, so the display tracks value continuously.
- NUM_DIGITS=1: idx stays 0; the guard still applies each slot.
- GUARD=0: no dead time; anodes switch directly between adjacent digits on the slot boundary edge.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, ACTIVE_LOW_AN=1.
- Reset release: rst pulsed, load never asserted. Edges 1-2 give an=1111, seg=FF. Edges 3-8 give an=1110, seg=88. Frame repeats every 32 cycles.
- Decode: load value=16'h12AF, dp_en=0, blank_lz=0. Lit slots are:
  - an=1110, seg=93
  - an=1101, seg=81
  - an=1011, seg=A2
  - an=0111, seg=ED
- Blanking: blank_lz=1.
  - value=16'h0050 gives digits 3,2 seg=FF, digit1=94, digit0=88.
  - value=16'h0000 gives only digit0=88 visible.
- DP on blanked digit: value=0, blank_lz=1, dp_en=4'b0100 gives digit2 seg=7F and digit0 seg=88.
- Load timing: value changes with load=0, giving no output change. Pulse load while digit1 is lit; seg shows the new code on the following edge.
- Async reset mid-slot: assert rst between edges while digit 2 is lit. an=1111 and seg=FF immediately; after release, scanning restarts at digit 0 and all shadows are cleared.
